// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle sequencer and the datapath.
// master: sequencer (drives selects/enables); slave: datapath side.
interface multicycle_control_fsm_if;
  // Instruction fields and memory handshake
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       mem_ready;

  // Datapath selects and raw enables
  logic       IRWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       ALUOp;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic [1:0] FlagW;

  modport master (
    input  Op,
    input  Funct,
    input  mem_ready,
    output IRWrite,
    output AdrSrc,
    output ALUSrcA,
    output ALUSrcB,
    output ResultSrc,
    output ALUOp,
    output NextPC,
    output RegW,
    output MemW,
    output Branch,
    output FlagW
  );

  modport slave (
    output Op,
    output Funct,
    output mem_ready,
    input  IRWrite,
    input  AdrSrc,
    input  ALUSrcA,
    input  ALUSrcB,
    input  ResultSrc,
    input  ALUOp,
    input  NextPC,
    input  RegW,
    input  MemW,
    input  Branch,
    input  FlagW
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle ARMv4 main sequencer: fetch/decode/execute/mem/wb.
// Ports: clk, rst (async high), bus (control bundle), state_o, instr_count.
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  multicycle_control_fsm_if.master bus,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             retire;

  // Funct[4:1] only matter to the ALU decoder, not to sequencing
  logic unused_funct;
  assign unused_funct = ^bus.Funct[4:1];

  // Local copies of the inputs keep the decode terse
  logic [1:0] op;
  logic       fi;
  logic       fs;
  logic       rdy;

  assign op  = bus.Op;
  assign fi  = bus.Funct[5];
  assign fs  = bus.Funct[0];
  assign rdy = bus.mem_ready;

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: begin
        state_d = rdy ? DECODE : FETCH;
      end
      DECODE: begin
        unique case (1'b1)
          (op == 2'b01):        state_d = MEMADR;
          (op == 2'b00) && !fi: state_d = EXECUTER;
          (op == 2'b00) && fi:  state_d = EXECUTEI;
          (op == 2'b10):        state_d = BRANCH;
          (op == 2'b11):        state_d = FETCH;
        endcase
      end
      MEMADR: begin
        state_d = fs ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        state_d = rdy ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        state_d = FETCH;
      end
      MEMWRITE: begin
        state_d = rdy ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        state_d = ALUWB;
      end
      EXECUTEI: begin
        state_d = ALUWB;
      end
      ALUWB: begin
        state_d = FETCH;
      end
      BRANCH: begin
        state_d = FETCH;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // An instruction retires on every path that lands back in FETCH,
  // including the Op=11 NOP leaving DECODE.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      DECODE:   retire = (op == 2'b11);
      MEMWB:    retire = 1'b1;
      MEMWRITE: retire = rdy;
      ALUWB:    retire = 1'b1;
      BRANCH:   retire = 1'b1;
      default:  retire = 1'b0;
    endcase
  end

  // Wraps naturally at 2^CNT_W
  assign cnt_d = retire ? cnt_q + 1'b1 : cnt_q;

  // Output decode
  always_comb begin
    bus.IRWrite   = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ALUSrcA   = 1'b0;
    bus.ALUSrcB   = 2'b00;
    bus.ResultSrc = 2'b00;
    bus.ALUOp     = 1'b0;
    bus.NextPC    = 1'b0;
    bus.RegW      = 1'b0;
    bus.MemW      = 1'b0;
    bus.Branch    = 1'b0;
    bus.FlagW     = 2'b00;
    case (state_q)
      FETCH: begin
        // PC+4 computed by the ALU; IR/PC load on the ready cycle only
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.IRWrite   = rdy;
        bus.NextPC    = rdy;
      end
      DECODE: begin
        // PC+8 for R15 reads
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      MEMADR: begin
        bus.ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        bus.AdrSrc = 1'b1;
      end
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegW      = 1'b1;
      end
      MEMWRITE: begin
        bus.AdrSrc = 1'b1;
        bus.MemW   = 1'b1;
      end
      EXECUTER: begin
        bus.ALUOp = 1'b1;
        bus.FlagW = {2{fs}};
      end
      EXECUTEI: begin
        bus.ALUSrcB = 2'b01;
        bus.ALUOp   = 1'b1;
        bus.FlagW   = {2{fs}};
      end
      ALUWB: begin
        bus.RegW = 1'b1;
      end
      BRANCH: begin
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
        bus.Branch    = 1'b1;
      end
      default: begin
        bus.RegW = 1'b0;
      end
    endcase
  end

  assign state_o     = state_q;
  assign instr_count = cnt_q;

endmodule
